// File: rtl/rgb_led_pkg.sv
// Shared types and colour constants for the RGB LED arbiter.
package rgb_led_pkg;

    typedef logic [2:0] rgb_t;

    // Colour encodings, ordered {R,G,B}
    localparam rgb_t OFF     = 3'b000;
    localparam rgb_t RED     = 3'b100;
    localparam rgb_t YELLOW  = 3'b110;
    localparam rgb_t GREEN   = 3'b010;
    localparam rgb_t CYAN    = 3'b011;
    localparam rgb_t BLUE    = 3'b001;
    localparam rgb_t MAGENTA = 3'b101;
    localparam rgb_t WHITE   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from last_owner+1, wrapping modulo NUM_REQ.
module rr_pick
    import rgb_led_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner_c,
    output logic               valid_c
);

    // Walk the search order backwards so the nearest candidate is written last
    always_comb begin
        winner_c = '0;
        valid_c  = 1'b0;
        for (int i = int'(NUM_REQ); i > 0; i--) begin
            logic [IDX_W-1:0] sel;
            sel = IDX_W'((32'(last_owner) + 32'(i)) % NUM_REQ);
            if (req[sel]) begin
                winner_c = sel;
                valid_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Time-sliced round-robin owner of the single RGB LED, with a dark gap
// between owners and registered LED/grant outputs.
module rgb_led_arbiter
    import rgb_led_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SLOT_CYCLES = 2000000,
    parameter int unsigned GAP_CYCLES  = 12000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   red,
    output logic                   green,
    output logic                   blue,
    output logic                   busy
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned MAX_CNT = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    rgb_t               rgb_q, rgb_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick_last_c;
    logic [IDX_W-1:0]   winner_c;
    logic               valid_c;
    logic [NUM_REQ-1:0] win_grant_c;
    rgb_t               win_rgb_c;
    rgb_t               own_rgb_c;
    logic               release_c;
    logic               expire_c;
    logic               others_c;

    // A direct hand-off (no gap) arbitrates from the owner being released
    assign pick_last_c = (state_q == GRANT) ? owner_q : last_owner_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req),
        .last_owner (pick_last_c),
        .winner_c   (winner_c),
        .valid_c    (valid_c)
    );

    assign win_grant_c = NUM_REQ'(1) << winner_c;
    assign win_rgb_c   = rgb_t'(colour_in >> (32'(winner_c) * 3));
    assign own_rgb_c   = rgb_t'(colour_in >> (32'(owner_q) * 3));
    assign release_c   = ~req[owner_q];
    assign expire_c    = (count_q == SLOT_LAST);
    assign others_c    = |(req & ~(NUM_REQ'(1) << owner_q));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        rgb_d        = rgb_q;
        busy_d       = busy_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                rgb_d   = OFF;
                busy_d  = 1'b0;
                count_d = '0;
                if (valid_c) begin
                    state_d = GRANT;
                    owner_d = winner_c;
                    grant_d = win_grant_c;
                    rgb_d   = win_rgb_c;
                    busy_d  = 1'b1;
                end
            end

            GRANT: begin
                busy_d = 1'b1;
                if (release_c || (expire_c && others_c)) begin
                    last_owner_d = owner_q;
                    grant_d      = '0;
                    rgb_d        = OFF;
                    count_d      = '0;
                    if (GAP_CYCLES == 0) begin
                        if (valid_c) begin
                            owner_d = winner_c;
                            grant_d = win_grant_c;
                            rgb_d   = win_rgb_c;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    // Uncontested expiry simply wraps the slot counter
                    rgb_d   = own_rgb_c;
                    count_d = expire_c ? '0 : count_q + CNT_W'(1);
                end
            end

            GAP: begin
                grant_d = '0;
                rgb_d   = OFF;
                busy_d  = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == GAP_LAST) begin
                    count_d = '0;
                    if (valid_c) begin
                        state_d = GRANT;
                        owner_d = winner_c;
                        grant_d = win_grant_c;
                        rgb_d   = win_rgb_c;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            rgb_q        <= OFF;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            rgb_q        <= rgb_d;
            busy_q       <= busy_d;
        end
    end

    assign grant = grant_q;
    assign red   = rgb_q[2];
    assign green = rgb_q[1];
    assign blue  = rgb_q[0];
    assign busy  = busy_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with NUM_REQ=4, SLOT_CYCLES=8, GAP_CYCLES=2.
module tb_rgb_led_arbiter;
    import rgb_led_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] colour_in;
    logic [3:0]  grant;
    logic        red, green, blue, busy;

    int nvec = 0;
    int nerr = 0;

    rgb_led_arbiter #(
        .NUM_REQ(4), .SLOT_CYCLES(8), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .colour_in(colour_in),
        .grant(grant), .red(red), .green(green), .blue(blue), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {busy, grant, rgb} in one vector
    task automatic expect_out(input string tag, input logic [3:0] g, input rgb_t c, input logic b);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {busy, grant, red, green, blue};
        exp = {b, g, c};
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed busy/grant/rgb=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting mid-cycle, checked before any edge
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out(tag, 4'b0000, OFF, 1'b0);
        step();
        expect_out({tag, "_held"}, 4'b0000, OFF, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = 4'b0000;
        colour_in = '0;

        reset_pulse("reset");
        repeat (3) step();
        expect_out("idle_after_reset", 4'b0000, OFF, 1'b0);

        // Single requester keeps the LED across several slot expiries
        req       = 4'b0010;
        colour_in = {OFF, OFF, YELLOW, OFF};
        step();
        expect_out("single_first", 4'b0010, YELLOW, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step();
            expect_out("single_hold", 4'b0010, YELLOW, 1'b1);
        end
        req = 4'b0000;
        step();
        expect_out("single_release", 4'b0000, OFF, 1'b1);
        step();
        expect_out("single_gap2", 4'b0000, OFF, 1'b1);
        step();
        expect_out("single_idle", 4'b0000, OFF, 1'b0);

        // Simultaneous requests: 0 first for a full slot, gap, then 2
        reset_pulse("reset2");
        req       = 4'b0101;
        colour_in = {OFF, BLUE, GREEN, RED};
        for (int i = 0; i < 8; i++) begin
            step();
            expect_out("sim_owner0", 4'b0001, RED, 1'b1);
        end
        step();
        expect_out("sim_gap1", 4'b0000, OFF, 1'b1);
        step();
        expect_out("sim_gap2", 4'b0000, OFF, 1'b1);
        step();
        expect_out("sim_owner2", 4'b0100, BLUE, 1'b1);

        // Owner colour tracked, non-owner colour ignored
        colour_in = {OFF, CYAN, GREEN, WHITE};
        step();
        expect_out("colour_track", 4'b0100, CYAN, 1'b1);

        // Owner 2 releases; 3 is next, then wrap to 0, then 1
        req       = 4'b1011;
        colour_in = {MAGENTA, CYAN, GREEN, WHITE};
        step();
        expect_out("rr_rel_gap1", 4'b0000, OFF, 1'b1);
        step();
        expect_out("rr_rel_gap2", 4'b0000, OFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            expect_out("rr_owner3", 4'b1000, MAGENTA, 1'b1);
        end
        step();
        expect_out("rr_gap_a", 4'b0000, OFF, 1'b1);
        step();
        expect_out("rr_gap_b", 4'b0000, OFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            expect_out("rr_wrap_owner0", 4'b0001, WHITE, 1'b1);
        end
        step();
        expect_out("rr_gap_c", 4'b0000, OFF, 1'b1);
        step();
        expect_out("rr_gap_d", 4'b0000, OFF, 1'b1);
        step();
        expect_out("rr_owner1", 4'b0010, GREEN, 1'b1);

        // Early release with nobody else waiting ends in IDLE
        reset_pulse("reset3");
        req       = 4'b0001;
        colour_in = {OFF, OFF, OFF, RED};
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("early_grant", 4'b0001, RED, 1'b1);
        end
        req = 4'b0000;
        step();
        expect_out("early_gap1", 4'b0000, OFF, 1'b1);
        step();
        expect_out("early_gap2", 4'b0000, OFF, 1'b1);
        step();
        expect_out("early_idle", 4'b0000, OFF, 1'b0);
        step();
        expect_out("early_idle_hold", 4'b0000, OFF, 1'b0);

        // Reset while requester 2 owns the LED restarts from requester 0
        reset_pulse("reset4");
        req       = 4'b0101;
        colour_in = {OFF, BLUE, OFF, RED};
        repeat (10) step();
        step();
        expect_out("mid_owner2", 4'b0100, BLUE, 1'b1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 expect_out("mid_reset_async", 4'b0000, OFF, 1'b0);
        step();
        expect_out("mid_reset_held", 4'b0000, OFF, 1'b0);
        rst_n = 1'b1;
        step();
        expect_out("mid_restart_0", 4'b0001, RED, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
